adv_timer_comparator_mc: RTL and testbench

Multi-channel compare/output unit for the advanced timer. It takes one shared timer counter and drives NUM_CHANNELS PWM-style outputs. Each channel has its own compare value, operation and output polarity, held in a shadow/active register pair. Updates apply either immediately or at the timer period boundary, so reprogramming mid-period is glitch-free. The block sits between the timer counter and the output pin mux, one instance per timer.

---
 rtl/adv_timer_comparator_mc_if.sv | 35 +++
 rtl/adv_timer_comparator_mc.sv | 100 ++++++++++
 tb/tb_adv_timer_comparator_mc.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adv_timer_comparator_mc_if.sv
// adv_timer_comparator_mc_if: control, config, timer and output bundle of the comparator
// The master drives control/config/timer inputs; the slave (comparator) drives the outputs.
interface adv_timer_comparator_mc_if #(
    parameter int NUM_BITS     = 16,
    parameter int NUM_CHANNELS = 4
);
    logic                             ctrl_active_i;
    logic                             ctrl_update_i;
    logic                             ctrl_rst_i;
    logic                             cfg_sync_upd_i;
    logic [NUM_CHANNELS*NUM_BITS-1:0] cfg_comp_i;
    logic [NUM_CHANNELS*3-1:0]        cfg_comp_op_i;
    logic [NUM_CHANNELS-1:0]          cfg_invert_i;
    logic                             timer_valid_i;
    logic                             timer_end_i;
    logic                             timer_sawtooth_i;
    logic [NUM_BITS-1:0]              timer_count_i;
    logic [NUM_CHANNELS-1:0]          result_o;
    logic [NUM_CHANNELS-1:0]          match_o;
    logic                             upd_pending_o;

    modport master (
        output ctrl_active_i, ctrl_update_i, ctrl_rst_i, cfg_sync_upd_i, cfg_comp_i,
               cfg_comp_op_i, cfg_invert_i, timer_valid_i, timer_end_i, timer_sawtooth_i,
               timer_count_i,
        input  result_o, match_o, upd_pending_o
    );

    modport slave (
        input  ctrl_active_i, ctrl_update_i, ctrl_rst_i, cfg_sync_upd_i, cfg_comp_i,
               cfg_comp_op_i, cfg_invert_i, timer_valid_i, timer_end_i, timer_sawtooth_i,
               timer_count_i,
        output result_o, match_o, upd_pending_o
    );
endinterface

// File: rtl/adv_timer_comparator_mc.sv
// adv_timer_comparator_mc: per-channel compare/PWM output stage with shadowed configuration
// Config loads immediately or at the period end; outputs are fully registered.
module adv_timer_comparator_mc #(
    parameter int NUM_BITS     = 16,
    parameter int NUM_CHANNELS = 4
) (
    input logic                      clk_i,
    input logic                      rstn_i,
    adv_timer_comparator_mc_if.slave bus
);
    localparam int NB = NUM_BITS;
    localparam int NC = NUM_CHANNELS;

    logic [NC*NB-1:0] sh_comp_q, sh_comp_d;
    logic [NC*3-1:0]  sh_op_q, sh_op_d;
    logic [NC-1:0]    sh_inv_q, sh_inv_d;
    logic             pending_q, pending_d;
    logic             load_imm, def_req, load_def, evaluate;
    logic [NC-1:0]    result, match;

    assign load_imm = bus.ctrl_update_i & ~bus.cfg_sync_upd_i;
    assign def_req  = bus.ctrl_update_i & bus.cfg_sync_upd_i;
    assign load_def = bus.timer_valid_i & bus.timer_end_i & pending_q & ~load_imm;
    assign evaluate = bus.timer_valid_i & bus.ctrl_active_i;

    // A request arriving with the period end still flushes the old shadow, so pending stays set
    always_comb begin
        sh_comp_d = def_req ? bus.cfg_comp_i    : sh_comp_q;
        sh_op_d   = def_req ? bus.cfg_comp_op_i : sh_op_q;
        sh_inv_d  = def_req ? bus.cfg_invert_i  : sh_inv_q;
        pending_d = load_imm ? 1'b0 : def_req ? 1'b1 : load_def ? 1'b0 : pending_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_comp_q <= '0;
            sh_op_q   <= '0;
            sh_inv_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            sh_comp_q <= sh_comp_d;
            sh_op_q   <= sh_op_d;
            sh_inv_q  <= sh_inv_d;
            pending_q <= pending_d;
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_ch
        logic [NB-1:0] comp_q, comp_d;
        logic [2:0]    op_q, op_d;
        logic          inv_q, inv_d, value_q, value_d, phase_q, phase_d, match_q, match_d;
        logic          hit, paired, ev_a, ev_b, val_a, val_b, ph_eval;

        // Ops 1/2/5/6 pair matches in centred mode: first match is A, second is B
        always_comb begin
            comp_d  = load_imm ? bus.cfg_comp_i[c*NB +: NB] : load_def ? sh_comp_q[c*NB +: NB] : comp_q;
            op_d    = load_imm ? bus.cfg_comp_op_i[c*3 +: 3] : load_def ? sh_op_q[c*3 +: 3] : op_q;
            inv_d   = load_imm ? bus.cfg_invert_i[c] : load_def ? sh_inv_q[c] : inv_q;
            hit     = bus.timer_valid_i & (comp_q == bus.timer_count_i);
            paired  = op_q inside {3'd1, 3'd2, 3'd5, 3'd6};
            ev_a    = hit & (bus.timer_sawtooth_i | ~paired | ~phase_q);
            ev_b    = bus.timer_sawtooth_i ? bus.timer_end_i & ~hit : hit & paired & phase_q;
            val_a   = (op_q == 3'd0 || op_q == 3'd2) ? 1'b1 :
                      (op_q == 3'd4 || op_q == 3'd6) ? 1'b0 :
                      (op_q == 3'd7) ? value_q : ~value_q;
            val_b   = (op_q == 3'd1 || op_q == 3'd2) ? 1'b0 :
                      (op_q == 3'd5 || op_q == 3'd6) ? 1'b1 : value_q;
            ph_eval = (op_q == 3'd7) ? 1'b0 :
                      (~bus.timer_sawtooth_i & paired & hit) ? ~phase_q : phase_q;
            value_d = bus.ctrl_rst_i ? 1'b0 : ~evaluate ? value_q : ev_a ? val_a : ev_b ? val_b : value_q;
            phase_d = (bus.ctrl_rst_i || op_d != op_q) ? 1'b0 : evaluate ? ph_eval : phase_q;
            match_d = ~bus.ctrl_rst_i & hit & bus.ctrl_active_i;
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                comp_q  <= '0;
                op_q    <= '0;
                inv_q   <= 1'b0;
                value_q <= 1'b0;
                phase_q <= 1'b0;
                match_q <= 1'b0;
            end else begin
                comp_q  <= comp_d;
                op_q    <= op_d;
                inv_q   <= inv_d;
                value_q <= value_d;
                phase_q <= phase_d;
                match_q <= match_d;
            end
        end

        assign result[c] = value_q ^ inv_q;
        assign match[c]  = match_q;
    end

    assign bus.result_o      = result;
    assign bus.match_o       = match;
    assign bus.upd_pending_o = pending_q;
endmodule

// File: tb/tb_adv_timer_comparator_mc.sv
// tb_adv_timer_comparator_mc: directed scenarios plus random traffic against an event-level model
// Each task drives its own stimulus and compares DUT outputs to constants and the model.
module tb_adv_timer_comparator_mc;
    localparam int NB = 16;
    localparam int NC = 4;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;

    adv_timer_comparator_mc_if #(.NUM_BITS(NB), .NUM_CHANNELS(NC)) bus ();
    adv_timer_comparator_mc #(.NUM_BITS(NB), .NUM_CHANNELS(NC)) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int m_comp[NC], m_op[NC], m_inv[NC], m_val[NC], m_ph[NC], m_mat[NC];
    int s_comp[NC], s_op[NC], s_inv[NC];
    int m_pend;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_comp[c] = 0; m_op[c] = 0; m_inv[c] = 0; m_val[c] = 0; m_ph[c] = 0; m_mat[c] = 0;
            s_comp[c] = 0; s_op[c] = 0; s_inv[c] = 0;
        end
        m_pend = 0;
    endtask

    // Event-level reference: classify each cycle as event A, B or none, then apply the op table
    task automatic model_step();
        bit imm, req, def;
        imm = bus.ctrl_update_i && !bus.cfg_sync_upd_i;
        req = bus.ctrl_update_i && bus.cfg_sync_upd_i;
        def = bus.timer_valid_i && bus.timer_end_i && m_pend != 0 && !imm;
        for (int c = 0; c < NC; c++) begin
            int ev, nv, np, nop;
            bit hit, pair;
            hit = bus.timer_valid_i && (m_comp[c] == int'(bus.timer_count_i));
            pair = m_op[c] inside {1, 2, 5, 6};
            nv = m_val[c]; np = m_ph[c]; ev = 0;
            if (bus.timer_valid_i && bus.ctrl_active_i) begin
                if (bus.timer_sawtooth_i) ev = hit ? 1 : (bus.timer_end_i ? 2 : 0);
                else if (hit) begin
                    ev = (pair && m_ph[c] != 0) ? 2 : 1;
                    if (pair) np = 1 - m_ph[c];
                end
                if (ev == 1) begin
                    case (m_op[c])
                        0, 2:    nv = 1;
                        1, 3, 5: nv = 1 - nv;
                        4, 6:    nv = 0;
                        default: ;
                    endcase
                end else if (ev == 2) begin
                    case (m_op[c])
                        1, 2:    nv = 0;
                        5, 6:    nv = 1;
                        default: ;
                    endcase
                end
                if (m_op[c] == 7) np = 0;
            end
            if (bus.ctrl_rst_i) begin nv = 0; np = 0; end
            m_mat[c] = (!bus.ctrl_rst_i && hit && bus.ctrl_active_i) ? 1 : 0;
            nop = imm ? int'(bus.cfg_comp_op_i[c*3 +: 3]) : def ? s_op[c] : m_op[c];
            if (nop != m_op[c]) np = 0;
            if (imm) begin
                m_comp[c] = int'(bus.cfg_comp_i[c*NB +: NB]); m_inv[c] = int'(bus.cfg_invert_i[c]);
            end else if (def) begin
                m_comp[c] = s_comp[c]; m_inv[c] = s_inv[c];
            end
            if (req) begin
                s_comp[c] = int'(bus.cfg_comp_i[c*NB +: NB]);
                s_op[c]   = int'(bus.cfg_comp_op_i[c*3 +: 3]);
                s_inv[c]  = int'(bus.cfg_invert_i[c]);
            end
            m_op[c] = nop; m_val[c] = nv; m_ph[c] = np;
        end
        m_pend = imm ? 0 : req ? 1 : def ? 0 : m_pend;
    endtask

    function automatic logic [NC-1:0] m_res();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = (m_val[c] ^ m_inv[c]) != 0;
        return r;
    endfunction

    function automatic logic [NC-1:0] m_mo();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = m_mat[c] != 0;
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(int c, int comp, int op, bit inv);
        bus.cfg_comp_i[c*NB +: NB] = NB'(comp);
        bus.cfg_comp_op_i[c*3 +: 3] = 3'(op);
        bus.cfg_invert_i[c] = inv;
    endtask

    task automatic cfg_load(bit sync);
        bus.timer_valid_i = 1'b0; bus.timer_end_i = 1'b0;
        bus.ctrl_update_i = 1'b1; bus.cfg_sync_upd_i = sync;
        tick();
        bus.ctrl_update_i = 1'b0;
    endtask

    task automatic crst();
        bus.timer_valid_i = 1'b0; bus.ctrl_rst_i = 1'b1;
        tick();
        bus.ctrl_rst_i = 1'b0;
    endtask

    task automatic cyc(int cnt, bit e, bit upd = 1'b0, bit sync = 1'b0);
        bus.timer_valid_i = 1'b1; bus.timer_count_i = NB'(cnt); bus.timer_end_i = e;
        bus.ctrl_update_i = upd; bus.cfg_sync_upd_i = sync;
        tick();
        bus.ctrl_update_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.ctrl_active_i = 1'b1; bus.ctrl_update_i = 1'b0; bus.ctrl_rst_i = 1'b0;
        bus.cfg_sync_upd_i = 1'b0; bus.cfg_comp_i = '0; bus.cfg_comp_op_i = '0; bus.cfg_invert_i = '0;
        bus.timer_valid_i = 1'b0; bus.timer_end_i = 1'b0; bus.timer_sawtooth_i = 1'b1; bus.timer_count_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        n_vec++;
        if ({bus.result_o, bus.match_o, bus.upd_pending_o} !== '0) begin
            n_err++; $display("FAIL reset_hold got %b required 0", {bus.result_o, bus.match_o, bus.upd_pending_o});
        end
        rstn_i = 1'b1;
        tick();
        n_vec++;
        if ({bus.result_o, bus.match_o, bus.upd_pending_o} !== '0) begin
            n_err++; $display("FAIL reset_release got %b required 0", {bus.result_o, bus.match_o, bus.upd_pending_o});
        end
    endtask

    task automatic test_sawtooth();
        for (int c = 0; c < NC; c++) set_cfg(c, 100 + c, 7, 1'b0);
        set_cfg(0, 3, 2, 1'b0);
        bus.timer_sawtooth_i = 1'b1;
        cfg_load(1'b0);
        crst();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++) begin
                cyc(k, k == 9);
                n_vec++;
                if (bus.result_o[0] !== (k >= 3 && k < 9)) begin
                    n_err++; $display("FAIL saw_result p=%0d k=%0d got %b required %b", p, k, bus.result_o[0], (k >= 3 && k < 9));
                end
                n_vec++;
                if (bus.match_o !== m_mo() || bus.match_o[0] !== (k == 3)) begin
                    n_err++; $display("FAIL saw_match p=%0d k=%0d got %b required %b", p, k, bus.match_o, m_mo());
                end
            end
    endtask

    task automatic test_centred();
        int seq[10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
        set_cfg(1, 2, 1, 1'b0);
        cfg_load(1'b0);
        crst();
        bus.timer_sawtooth_i = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 10; i++) begin
                cyc(seq[i], i == 9);
                n_vec++;
                if (bus.result_o[1] !== (i >= 2 && i < 8)) begin
                    n_err++; $display("FAIL centred_ch1 p=%0d i=%0d got %b required %b", p, i, bus.result_o[1], (i >= 2 && i < 8));
                end
                n_vec++;
                if (bus.result_o !== m_res() || bus.match_o !== m_mo()) begin
                    n_err++; $display("FAIL centred_all p=%0d i=%0d got %b/%b required %b/%b", p, i, bus.result_o, bus.match_o, m_res(), m_mo());
                end
            end
    endtask

    task automatic test_deferred();
        bus.timer_sawtooth_i = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++) begin
                if (p == 0 && k == 4) set_cfg(0, 6, 2, 1'b0);
                cyc(k, k == 9, p == 0 && k == 4, 1'b1);
                n_vec++;
                if (bus.upd_pending_o !== (p == 0 && k >= 4 && k < 9)) begin
                    n_err++; $display("FAIL defer_pending p=%0d k=%0d got %b required %b", p, k, bus.upd_pending_o, (p == 0 && k >= 4 && k < 9));
                end
                n_vec++;
                if (bus.match_o[0] !== (k == (p == 0 ? 3 : 6))) begin
                    n_err++; $display("FAIL defer_match p=%0d k=%0d got %b required %b", p, k, bus.match_o[0], (k == (p == 0 ? 3 : 6)));
                end
            end
    endtask

    task automatic test_overwrite();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++) begin
                bit req;
                req = (p == 0) && (k == 1 || k == 4);
                if (req) set_cfg(0, k == 1 ? 5 : 7, 2, 1'b0);
                cyc(k, k == 9, req, 1'b1);
                n_vec++;
                if (bus.upd_pending_o !== (p == 0 && k >= 1 && k < 9)) begin
                    n_err++; $display("FAIL over_pending p=%0d k=%0d got %b required %b", p, k, bus.upd_pending_o, (p == 0 && k >= 1 && k < 9));
                end
                n_vec++;
                if (bus.match_o[0] !== (k == (p == 0 ? 6 : 7))) begin
                    n_err++; $display("FAIL over_match p=%0d k=%0d got %b required %b", p, k, bus.match_o[0], (k == (p == 0 ? 6 : 7)));
                end
            end
    endtask

    task automatic test_invert_rst();
        crst();
        set_cfg(2, 2, 0, 1'b1);
        cfg_load(1'b0);
        n_vec++;
        if (bus.result_o[2] !== 1'b1) begin
            n_err++; $display("FAIL invert_idle got %b required 1", bus.result_o[2]);
        end
        for (int k = 0; k < 3; k++) cyc(k, 1'b0);
        n_vec++;
        if (bus.result_o[2] !== 1'b0 || bus.result_o !== m_res()) begin
            n_err++; $display("FAIL invert_set got %b required %b", bus.result_o, m_res());
        end
        cfg_load(1'b1);
        bus.ctrl_rst_i = 1'b1;
        cyc(2, 1'b0);
        bus.ctrl_rst_i = 1'b0;
        n_vec++;
        if (bus.result_o[2] !== 1'b1 || bus.match_o !== '0 || bus.upd_pending_o !== 1'b1) begin
            n_err++; $display("FAIL ctrl_rst got res=%b match=%b pend=%b required res[2]=1 match=0 pend=1", bus.result_o, bus.match_o, bus.upd_pending_o);
        end
        cfg_load(1'b0);
        n_vec++;
        if (bus.upd_pending_o !== 1'b0) begin
            n_err++; $display("FAIL imm_clears_pending got %b required 0", bus.upd_pending_o);
        end
    endtask

    task automatic test_op7_inactive();
        logic [NC-1:0] snap;
        set_cfg(3, 1, 0, 1'b0);
        cfg_load(1'b0);
        for (int k = 0; k < 3; k++) cyc(k, 1'b0);
        set_cfg(3, 4, 7, 1'b0);
        cfg_load(1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(k, k == 9);
            n_vec++;
            if (bus.result_o[3] !== 1'b1 || bus.match_o[3] !== (k == 4)) begin
                n_err++; $display("FAIL op7_hold k=%0d got res=%b match=%b required res[3]=1 match[3]=%b", k, bus.result_o[3], bus.match_o[3], (k == 4));
            end
        end
        bus.ctrl_active_i = 1'b0;
        snap = m_res();
        for (int k = 0; k < 10; k++) begin
            cyc(k, k == 9);
            n_vec++;
            if (bus.result_o !== snap || bus.match_o !== '0) begin
                n_err++; $display("FAIL inactive_hold k=%0d got res=%b match=%b required res=%b match=0", k, bus.result_o, bus.match_o, snap);
            end
        end
        bus.ctrl_active_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        set_cfg(0, 4, 2, 1'b0);
        cfg_load(1'b1);
        set_cfg(0, 5, 2, 1'b0);
        cyc(9, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (bus.upd_pending_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_def_end_pending got %b required 1", bus.upd_pending_o);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(k, k == 9);
            n_vec++;
            if (bus.match_o[0] !== (k == 4) || bus.upd_pending_o !== (k < 9)) begin
                n_err++; $display("FAIL b2b_old_shadow k=%0d got match=%b pend=%b required match=%b pend=%b", k, bus.match_o[0], bus.upd_pending_o, (k == 4), (k < 9));
            end
        end
        set_cfg(0, 6, 2, 1'b0);
        cfg_load(1'b1);
        set_cfg(0, 2, 2, 1'b0);
        cyc(9, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (bus.upd_pending_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_imm_end_pending got %b required 0", bus.upd_pending_o);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(k, k == 9);
            n_vec++;
            if (bus.match_o[0] !== (k == 2) || bus.result_o !== m_res()) begin
                n_err++; $display("FAIL b2b_imm_wins k=%0d got match=%b res=%b required match=%b res=%b", k, bus.match_o[0], bus.result_o, (k == 2), m_res());
            end
        end
    endtask

    task automatic test_async_reset();
        cfg_load(1'b1);
        for (int k = 0; k < 5; k++) cyc(k, 1'b0);
        #2 rstn_i = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({bus.result_o, bus.match_o, bus.upd_pending_o} !== '0) begin
            n_err++; $display("FAIL async_reset got %b required 0", {bus.result_o, bus.match_o, bus.upd_pending_o});
        end
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        n_vec++;
        if ({bus.result_o, bus.match_o, bus.upd_pending_o} !== '0) begin
            n_err++; $display("FAIL async_reset_hold got %b required 0", {bus.result_o, bus.match_o, bus.upd_pending_o});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                for (int c = 0; c < NC; c++)
                    set_cfg(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            if (i % 60 == 0) bus.timer_sawtooth_i = $urandom_range(0, 1) == 1;
            bus.ctrl_update_i  = $urandom_range(0, 9) == 0;
            bus.cfg_sync_upd_i = $urandom_range(0, 1) == 1;
            bus.ctrl_rst_i     = $urandom_range(0, 19) == 0;
            bus.ctrl_active_i  = $urandom_range(0, 7) != 0;
            bus.timer_valid_i  = $urandom_range(0, 5) != 0;
            bus.timer_end_i    = $urandom_range(0, 4) == 0;
            bus.timer_count_i  = NB'($urandom_range(0, 7));
            tick();
            n_vec++;
            if (bus.result_o !== m_res() || bus.match_o !== m_mo() || bus.upd_pending_o !== (m_pend != 0)) begin
                n_err++; $display("FAIL random i=%0d got res=%b match=%b pend=%b required res=%b match=%b pend=%b",
                                  i, bus.result_o, bus.match_o, bus.upd_pending_o, m_res(), m_mo(), m_pend != 0);
            end
        end
        bus.ctrl_update_i = 1'b0; bus.ctrl_rst_i = 1'b0; bus.ctrl_active_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sawtooth();
        test_centred();
        test_deferred();
        test_overwrite();
        test_invert_rst();
        test_op7_inactive();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
